// File: rtl/input_debounce.sv
// Two-flop-or-deeper synchronizer plus independent per-bit debounce for the 12 used controller bits.
// Optional opposite-direction cleaning on the D-pad is enabled with INPUT_DEBOUNCE_SOCD_EN.
module input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cont1_key,
    output logic        dpad_up,
    output logic        dpad_down,
    output logic        dpad_left,
    output logic        dpad_right,
    output logic        button_a,
    output logic        button_b,
    output logic        button_x,
    output logic        button_y,
    output logic        button_trig_l,
    output logic        button_trig_r,
    output logic        button_select,
    output logic        button_start,
    output logic        input_changed
);

    localparam int NB = 12;
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Packed order: [9:0] = key[9:0], [10] = select, [11] = start.
    logic [NB-1:0] key_used;
    logic          unused_keys;

    assign key_used    = {cont1_key[15:14], cont1_key[9:0]};
    assign unused_keys = ^cont1_key[13:10];

    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0] cnt_q  [NB];
    logic [CW-1:0] cnt_d  [NB];
    logic [NB-1:0] stable_q, stable_d;
    logic [NB-1:0] clean;
    logic [NB-1:0] out_q, out_d;
    logic          changed_q, changed_d;

    always_comb begin
        sync_d[0] = key_used;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // A matching sample, or a qualifying flip, leaves the counter at zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_q[SYNC_STAGES-1][i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        clean = stable_q;
`ifdef INPUT_DEBOUNCE_SOCD_EN
        if (stable_q[0] && stable_q[1]) begin
            clean[1:0] = 2'b00;
        end
        if (stable_q[2] && stable_q[3]) begin
            clean[3:2] = 2'b00;
        end
`endif
        out_d     = clean;
        changed_d = (out_d != out_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q  <= '0;
            out_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q  <= stable_d;
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign dpad_up       = out_q[0];
    assign dpad_down     = out_q[1];
    assign dpad_left     = out_q[2];
    assign dpad_right    = out_q[3];
    assign button_a      = out_q[4];
    assign button_b      = out_q[5];
    assign button_x      = out_q[6];
    assign button_y      = out_q[7];
    assign button_trig_l = out_q[8];
    assign button_trig_r = out_q[9];
    assign button_select = out_q[10];
    assign button_start  = out_q[11];
    assign input_changed = changed_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed, table-driven bench for input_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A clean edge reaches the outputs on the 7th edge after the edge that first samples it.
module tb_input_debounce;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cont1_key;
    logic        dpad_up, dpad_down, dpad_left, dpad_right;
    logic        button_a, button_b, button_x, button_y;
    logic        button_trig_l, button_trig_r, button_select, button_start;
    logic        input_changed;
    logic [11:0] outs;

`ifdef INPUT_DEBOUNCE_SOCD_EN
    localparam bit SOCD = 1'b1;
`else
    localparam bit SOCD = 1'b0;
`endif

    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .cont1_key     (cont1_key),
        .dpad_up       (dpad_up),
        .dpad_down     (dpad_down),
        .dpad_left     (dpad_left),
        .dpad_right    (dpad_right),
        .button_a      (button_a),
        .button_b      (button_b),
        .button_x      (button_x),
        .button_y      (button_y),
        .button_trig_l (button_trig_l),
        .button_trig_r (button_trig_r),
        .button_select (button_select),
        .button_start  (button_start),
        .input_changed (input_changed)
    );

    always #5 clk = ~clk;

    assign outs = {button_start, button_select, button_trig_r, button_trig_l,
                   button_y, button_x, button_b, button_a,
                   dpad_right, dpad_left, dpad_down, dpad_up};

    typedef struct {
        logic        rst;
        logic [15:0] key;
        logic [11:0] exp_out;
        logic        exp_chg;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void row(input logic rst, input logic [15:0] key,
                                input logic [11:0] eo, input logic ec);
        vec_t v;
        v.rst     = rst;
        v.key     = key;
        v.exp_out = eo;
        v.exp_chg = ec;
        vecs.push_back(v);
    endfunction

    // Holds key for rows cycles; output moves prev->nxt on row flip (0 = never).
    function automatic void hold(input logic [15:0] key, input int rows,
                                 input logic [11:0] prev, input logic [11:0] nxt,
                                 input int flip);
        for (int j = 1; j <= rows; j++) begin
            row(1'b0, key, (flip != 0 && j >= flip) ? nxt : prev, (j == flip));
        end
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %03h expected %03h", name, act, exp);
    endtask

    initial begin
        logic [11:0] all_on;
        all_on = SOCD ? 12'hFF0 : 12'hFFF;

        // Clean press of A.
        hold(16'h0010, 8, 12'h000, 12'h010, 7);
        // Bounce on B: 1,1,0 then steady 1s; the last restart is row 4, so it lands on row 10.
        for (int j = 1; j <= 12; j++) begin
            row(1'b0, (j == 3) ? 16'h0010 : 16'h0030,
                (j >= 10) ? 12'h030 : 12'h010, (j == 10));
        end
        // Select, start and down together.
        hold(16'hC032, 8, 12'h030, 12'hC32, 7);
        // Release everything: same latency as press.
        hold(16'h0000, 8, 12'hC32, 12'h000, 7);
        // X then Y one cycle apart: back-to-back change pulses.
        row(1'b0, 16'h0040, 12'h000, 1'b0);
        hold(16'h00C0, 5, 12'h000, 12'h000, 0);
        row(1'b0, 16'h00C0, 12'h040, 1'b1);
        row(1'b0, 16'h00C0, 12'h0C0, 1'b1);
        row(1'b0, 16'h00C0, 12'h0C0, 1'b0);
        hold(16'h0000, 8, 12'h0C0, 12'h000, 7);
        // Reset one edge before L1 would qualify; it must start again from zero.
        hold(16'h0100, 5, 12'h000, 12'h000, 0);
        row(1'b1, 16'h0100, 12'h000, 1'b0);
        hold(16'h0100, 8, 12'h000, 12'h100, 7);
        // Opposite directions.
        hold(16'h0103, 8, 12'h100, SOCD ? 12'h100 : 12'h103, SOCD ? 0 : 7);
        hold(16'h0101, 8, SOCD ? 12'h100 : 12'h103, 12'h101, 7);
        hold(16'h010D, 8, 12'h101, SOCD ? 12'h101 : 12'h10D, SOCD ? 0 : 7);

        // Keys held high through reset, then released.
        reset     = 1'b1;
        cont1_key = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold%0d out", c), outs, 12'h000);
            check($sformatf("rst_hold%0d chg", c), {11'b0, input_changed}, 12'h000);
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            check($sformatf("rst_rel%0d out", e), outs, (e >= 7) ? all_on : 12'h000);
            check($sformatf("rst_rel%0d chg", e), {11'b0, input_changed}, {11'b0, e == 7});
        end

        reset     = 1'b1;
        cont1_key = 16'h0000;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_clear out", outs, 12'h000);
        end
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            reset     = vecs[k].rst;
            cont1_key = vecs[k].key;
            @(posedge clk); #1;
            check($sformatf("vec%0d out", k), outs, vecs[k].exp_out);
            check($sformatf("vec%0d chg", k), {11'b0, input_changed}, {11'b0, vecs[k].exp_chg});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
